vga_fb_arbiter: RTL

Arbitrates the single port of the frame-buffer RAM between two requesters: the display fetch path and a pixel writer such as a draw or CPU engine. The block sits beside vga_timing and uses its hcount/vcount/hblnk/vblnk outputs to schedule writer access into blanking intervals only. During active video the display fetch has the port exclusively, so the picture never tears or starves.

---
 rtl/vga_pkg.sv | 16 +
 rtl/vga_fb_rd_pipe.sv | 38 +++
 rtl/vga_fb_arbiter.sv | 115 +++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared VGA constants (800x600@60 timing totals) and frame-buffer arbiter types.
package vga_pkg;

    localparam int H_Tot_time = 1056;
    localparam int V_Tot_time = 628;

    localparam int FB_ADDR_W = 19;
    localparam int FB_DATA_W = 12;

    typedef enum logic [1:0] {
        ST_ACTIVE,
        ST_BLANK,
        ST_GUARD
    } fb_arb_state_t;

endpackage

// File: rtl/vga_fb_rd_pipe.sv
// Display read return path: valid delay line of depth 1+MEM_LAT with registered read data.
module vga_fb_rd_pipe
    import vga_pkg::*;
#(
    parameter int DATA_W  = FB_DATA_W,
    parameter int MEM_LAT = 1
) (
    input  logic              pclk_i,
    input  logic              rst_i,
    input  logic              rd_iss_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              rd_valid_o,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [MEM_LAT:0]  vld_q, vld_d;
    logic [DATA_W-1:0] data_q, data_d;

    // The bit one stage before the output marks the cycle the RAM word is on mem_rdata.
    always_comb begin
        vld_d  = {vld_q[MEM_LAT-1:0], rd_iss_i};
        data_d = vld_q[MEM_LAT-1] ? mem_rdata_i : data_q;
    end

    always_ff @(posedge pclk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_q  <= '0;
            data_q <= '0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
        end
    end

    assign rd_valid_o = vld_q[MEM_LAT];
    assign rd_data_o  = data_q;

endmodule

// File: rtl/vga_fb_arbiter.sv
// Frame-buffer port arbiter: display reads always win; writer gets the port only in blanking,
// and is locked out during the final GUARD_CYC cycles of a line that precedes active video.
module vga_fb_arbiter
    import vga_pkg::*;
#(
    parameter int ADDR_W    = FB_ADDR_W,
    parameter int DATA_W    = FB_DATA_W,
    parameter int MEM_LAT   = 1,
    parameter int GUARD_CYC = 4
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic [10:0]       hcount,
    input  logic [10:0]       vcount,
    input  logic              hblnk,
    input  logic              vblnk,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [15:0]       wr_stall_cnt
);

    localparam logic [10:0] H_GUARD = 11'(H_Tot_time - GUARD_CYC);
    localparam logic [10:0] V_LAST  = 11'(V_Tot_time - 1);

    fb_arb_state_t     state_q, state_d;
    logic              guard, rd_gnt, wr_gnt;
    logic              mem_en_q, mem_en_d, mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [15:0]       stall_q, stall_d;

    // True at the tail of any line whose successor is an active line.
    assign guard = (hcount >= H_GUARD) && (!vblnk || (vcount == V_LAST));

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACTIVE: if ((hblnk || vblnk) && !guard) state_d = ST_BLANK;
            ST_BLANK:  if (guard) state_d = ST_GUARD;
            ST_GUARD: begin
                if (!hblnk && !vblnk)     state_d = ST_ACTIVE;
                else if (vblnk && !guard) state_d = ST_BLANK;
            end
            default:   state_d = ST_ACTIVE;
        endcase
    end

    // The guard term closes the write window the same cycle the guard region starts.
    assign rd_gnt = rd_req;
    assign wr_gnt = (state_q == ST_BLANK) && !guard && wr_req && !rd_req;
    assign wr_ack = wr_gnt;

    always_comb begin
        mem_en_d    = rd_gnt || wr_gnt;
        mem_we_d    = wr_gnt;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (rd_gnt) begin
            mem_addr_d = rd_addr;
        end else if (wr_gnt) begin
            mem_addr_d  = wr_addr;
            mem_wdata_d = wr_data;
        end
        stall_d = stall_q;
        if (wr_req && !wr_gnt && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_ACTIVE;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            stall_q     <= '0;
        end else begin
            state_q     <= state_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            stall_q     <= stall_d;
        end
    end

    assign mem_en       = mem_en_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign wr_stall_cnt = stall_q;

    vga_fb_rd_pipe #(
        .DATA_W  (DATA_W),
        .MEM_LAT (MEM_LAT)
    ) u_rd_pipe (
        .pclk_i      (pclk),
        .rst_i       (rst),
        .rd_iss_i    (mem_en_q && !mem_we_q),
        .mem_rdata_i (mem_rdata),
        .rd_valid_o  (rd_valid),
        .rd_data_o   (rd_data)
    );

endmodule
